lyr2_seq: RTL and testbench
===========================

// Module: lyr2_seq
// PURPOSE
//  Time-multiplexed sequencer wrapped around one combinational 2-input fixed-point MAC (mult x2 + bias).
//  Accepts a 2-element Q8.8 input vector and steps the shared MAC through N_OUT neurons, one per cycle.
//  Applies optional ReLU to each result, buffers the N_OUT results and presents them as one output vector.
//  Sits between the layer-1 outputs and the next decoder layer. Valid/ready handshakes on both sides.
// PARAMETERS
//  N_OUT   4   neurons per input vector; legal range 1..16
//  DW      16  data/weight/bias width (Q8.8, two's complement)
//  ACT_EN  1   1 = ReLU on each MAC result, 0 = pass result through unchanged
// PORTS
//  clk        in   1            clock, all state updates on rising edge
//  rst_n      in   1            asynchronous active-low reset
//  in_valid   in   1            input vector valid
//  in_ready   out  1            block can accept an input vector
//  in_d1      in   DW           input element 1
//  in_d2      in   DW           input element 2
//  w_flat     in   N_OUT*3*DW   neuron i: [3DW*i +: DW]=w1, [+DW]=w2, [+2DW]=b; static during RUN
//  mac_d1     out  DW           to MAC d1 (captured in_d1)
//  mac_d2     out  DW           to MAC d2 (captured in_d2)
//  mac_w1     out  DW           to MAC w1 (w1 of current neuron)
//  mac_w2     out  DW           to MAC w2 (w2 of current neuron)
//  mac_b      out  DW           to MAC b  (b of current neuron)
//  mac_res    in   DW           MAC result, combinational from mac_* in the same cycle
//  out_valid  out  1            output vector valid
//  out_ready  in   1            downstream accepts output vector
//  out_vec    out  N_OUT*DW     neuron i result at [DW*i +: DW]
//  busy       out  1            high in RUN and DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, captured d1/d2=0, all buffer entries=0.
//   Outputs: in_ready=1, out_valid=0, busy=0, out_vec=0. mac_* reflect zeroed regs and idx 0.
//  FSM states IDLE, RUN, DONE:
//   IDLE: in_ready=1. in_valid=1 -> capture in_d1/in_d2, idx<=0, go RUN.
//   RUN: in_ready=0. mac_* driven from captured data and neuron idx. Each cycle buf[idx]<=act(mac_res).
//    idx==N_OUT-1 -> go DONE, idx<=0. Otherwise idx<=idx+1.
//   DONE: out_valid=1, out_vec=buf. out_ready=1 -> go IDLE, out_valid drops next cycle.
//    out_ready=0 -> hold state; out_vec stable.
//  Latency: accept edge -> out_valid high after N_OUT+1 rising edges. Throughput: one vector per N_OUT+2 cycles min.
//  in_ready is combinational from state only (IDLE). No dependence on in_valid or out_ready.
//  in_valid during RUN/DONE: ignored; upstream holds data until in_ready.
//  Next vector not accepted in the same cycle DONE is exited; it is accepted in IDLE the cycle after.
//  act(): ACT_EN=1 -> res[DW-1] ? 0 : res; ACT_EN=0 -> res.
//   No saturation. MAC overflow wraps modulo 2^DW upstream and is passed through as-is.
//  N_OUT=1: RUN lasts exactly one cycle.
//  Reset asserted mid-RUN or in DONE: immediate return to reset values; partial results discarded.
//  idx width = clog2(N_OUT), minimum 1 bit; never exceeds N_OUT-1.
// TESTING
//  T1 N_OUT=4, ACT_EN=1. d1=0x0100, d2=0x0200.
//   Weights (w1,w2,b): n0 (0x0100,0x0100,0), n1 (0x0080,0,0x0040), n2 (0xFF00,0,0), n3 (0,0x0100,0x0100).
//   Required out_vec = {0x0300,0x0000,0x00C0,0x0300} [n3..n0]; out_valid on 5th edge after accept.
//  T2 Same stimulus, ACT_EN=0 -> n2 result = 0xFF00 (-1.0) passed through unchanged.
//  T3 out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_vec unchanged, in_ready=0.
//   Raise out_ready -> IDLE next cycle.
//  T4 in_valid held high with new d1=0x0500 during RUN.
//   Required: ignored and first result unaffected; 0x0500 is accepted only after DONE->IDLE.
//  T5 rst_n pulsed low on the 2nd RUN cycle -> out_valid=0, busy=0, in_ready=1, out_vec=0 immediately.
//   Next vector processes normally.
//  T6 Back-to-back: in_valid and out_ready held high for 3 vectors.
//   Required: each vector correct, with exactly N_OUT+2 cycles between accepts.

Source files
------------

// File: rtl/lyr2_seq_if.sv
// lyr2_seq_if: handshake bundle around the layer-2 sequencer.
//   in_valid/in_ready/in_d1/in_d2 : upstream input vector channel
//   out_valid/out_ready/out_vec   : downstream result vector channel
//   busy                          : sequencer is in RUN or DONE
// The slave modport is the sequencer's view. The master modport is the view of
// the logic that drives it.
interface lyr2_seq_if #(
   parameter int N_OUT = 4,
   parameter int DW    = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DW-1:0]         in_d1;
   logic [DW-1:0]         in_d2;
   logic                  out_valid;
   logic                  out_ready;
   logic [N_OUT*DW-1:0]   out_vec;
   logic                  busy;

   modport slave (
      input  in_valid, in_d1, in_d2, out_ready,
      output in_ready, out_valid, out_vec, busy
   );

   modport master (
      output in_valid, in_d1, in_d2, out_ready,
      input  in_ready, out_valid, out_vec, busy
   );
endinterface

// File: rtl/lyr2_seq.sv
// lyr2_seq: time-multiplexed sequencer around one external 2-input Q8.8 MAC.
// It captures a 2-element input vector, steps the shared MAC through N_OUT
// neurons at one per cycle, applies an optional ReLU, and buffers the results.
// It then presents the whole result vector through a valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ifc (slave)       : input/output handshake channels and busy
//   w_flat            : per-neuron {b, w2, w1}. Must stay static while RUN.
//   mac_d1..mac_b     : operands to the external MAC
//   mac_res           : MAC result, combinational from mac_* in the same cycle
module lyr2_seq #(
   parameter int N_OUT  = 4,
   parameter int DW     = 16,
   parameter bit ACT_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   lyr2_seq_if.slave             ifc,
   input  logic [N_OUT*3*DW-1:0] w_flat,
   output logic [DW-1:0]         mac_d1,
   output logic [DW-1:0]         mac_d2,
   output logic [DW-1:0]         mac_w1,
   output logic [DW-1:0]         mac_w2,
   output logic [DW-1:0]         mac_b,
   input  logic [DW-1:0]         mac_res
);

   localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                     state_q, state_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [DW-1:0]              d1_q, d2_q;
   logic [N_OUT-1:0][DW-1:0]   res_q;
   logic                       cap;
   logic                       in_ready, out_valid, busy;
   logic [DW-1:0]              act_res;

   // Packed view of the weight bus: [neuron][0=w1,1=w2,2=b]
   logic [N_OUT-1:0][2:0][DW-1:0] w_arr;
   assign w_arr = w_flat;

   assign mac_d1 = d1_q;
   assign mac_d2 = d2_q;
   assign mac_w1 = w_arr[idx_q][0];
   assign mac_w2 = w_arr[idx_q][1];
   assign mac_b  = w_arr[idx_q][2];

   // The ReLU only tests the sign bit. A wrapped MAC overflow passes through as it is.
   assign act_res = (ACT_EN && mac_res[DW-1]) ? '0 : mac_res;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cap       = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (ifc.in_valid) begin
               cap     = 1'b1;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (idx_q == IW'(N_OUT-1)) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            // The next vector is accepted in IDLE on the following cycle, not here.
            if (ifc.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (cap) begin
            d1_q <= ifc.in_d1;
            d2_q <= ifc.in_d2;
         end
         if (state_q == RUN) res_q[idx_q] <= act_res;
      end
   end

   assign ifc.in_ready  = in_ready;
   assign ifc.out_valid = out_valid;
   assign ifc.busy      = busy;
   // Packed [neuron][bit] puts neuron i at [DW*i +: DW].
   assign ifc.out_vec   = res_q;

endmodule

// File: tb/tb_lyr2_seq.sv
module tb_lyr2_seq;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference Q8.8 MAC: (d1*w1 + d2*w2) >> 8 + b, wrapping to DW bits.
   function automatic logic [DW-1:0] mac(input logic [DW-1:0] d1, d2, w1, w2, b);
      logic signed [31:0] p;
      p = $signed(d1) * $signed(w1) + $signed(d2) * $signed(w2);
      return p[23:8] + b;
   endfunction

   // Neuron i = {b, w2, w1}; n3..n0
   logic [4*3*DW-1:0] w4 = {48'h0100_0100_0000, 48'h0000_0000_FF00,
                            48'h0040_0000_0080, 48'h0000_0100_0100};
   logic [3*DW-1:0]   w1n = 48'h0000_0100_0100;

   // A: ACT_EN=1 N_OUT=4, B: ACT_EN=0 N_OUT=4 (mirrors A's inputs), C: N_OUT=1
   lyr2_seq_if #(.N_OUT(4), .DW(DW)) ifa ();
   lyr2_seq_if #(.N_OUT(4), .DW(DW)) ifb ();
   lyr2_seq_if #(.N_OUT(1), .DW(DW)) ifc ();

   assign ifb.in_valid  = ifa.in_valid;
   assign ifb.in_d1     = ifa.in_d1;
   assign ifb.in_d2     = ifa.in_d2;
   assign ifb.out_ready = ifa.out_ready;

   logic [DW-1:0] ad1, ad2, aw1, aw2, ab, ares;
   logic [DW-1:0] bd1, bd2, bw1, bw2, bb, bres;
   logic [DW-1:0] cd1, cd2, cw1, cw2, cb, cres;
   assign ares = mac(ad1, ad2, aw1, aw2, ab);
   assign bres = mac(bd1, bd2, bw1, bw2, bb);
   assign cres = mac(cd1, cd2, cw1, cw2, cb);

   lyr2_seq #(.N_OUT(4), .DW(DW), .ACT_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .ifc(ifa), .w_flat(w4),
      .mac_d1(ad1), .mac_d2(ad2), .mac_w1(aw1), .mac_w2(aw2), .mac_b(ab), .mac_res(ares));

   lyr2_seq #(.N_OUT(4), .DW(DW), .ACT_EN(1'b0)) u_dut_lin (
      .clk(clk), .rst_n(rst_n), .ifc(ifb), .w_flat(w4),
      .mac_d1(bd1), .mac_d2(bd2), .mac_w1(bw1), .mac_w2(bw2), .mac_b(bb), .mac_res(bres));

   lyr2_seq #(.N_OUT(1), .DW(DW), .ACT_EN(1'b1)) u_dut_n1 (
      .clk(clk), .rst_n(rst_n), .ifc(ifc), .w_flat(w1n),
      .mac_d1(cd1), .mac_d2(cd2), .mac_w1(cw1), .mac_w2(cw2), .mac_b(cb), .mac_res(cres));

   localparam logic [63:0] EXP_A1 = 64'h0300_0000_00C0_0300; // d=(1,2) relu
   localparam logic [63:0] EXP_B1 = 64'h0300_FF00_00C0_0300; // d=(1,2) linear
   localparam logic [63:0] EXP_A2 = 64'h0300_0000_02C0_0700; // d=(5,2) relu
   localparam logic [63:0] EXP_B2 = 64'h0300_FB00_02C0_0700; // d=(5,2) linear
   localparam logic [63:0] EXP_A3 = 64'h0200_0000_0140_0300; // d=(2,1) relu

   // Accepts a vector on A/B, then checks the latency and both results.
   task automatic run_vec(input string tag, input logic [DW-1:0] d1, d2,
                          input logic [63:0] ea, eb);
      ifa.in_d1 = d1; ifa.in_d2 = d2; ifa.in_valid = 1'b1; ifa.out_ready = 1'b0;
      tick();                                   // accept edge (1)
      ifa.in_valid = 1'b0;
      chk({tag, "_busy"}, ifa.busy, 1'b1);
      chk({tag, "_rdy"}, ifa.in_ready, 1'b0);
      repeat (3) tick();                        // edges 2..4
      chk({tag, "_vld_early"}, ifa.out_valid, 1'b0);
      tick();                                   // edge 5
      chk({tag, "_vld"}, ifa.out_valid, 1'b1);
      chk({tag, "_vec"}, ifa.out_vec, ea);
      chk({tag, "_vec_lin"}, ifb.out_vec, eb);
   endtask

   initial begin
      ifa.in_valid = 1'b0; ifa.in_d1 = '0; ifa.in_d2 = '0; ifa.out_ready = 1'b0;
      ifc.in_valid = 1'b0; ifc.in_d1 = '0; ifc.in_d2 = '0; ifc.out_ready = 1'b0;
      #12;
      // Reset state
      chk("rst_rdy", ifa.in_ready, 1'b1);
      chk("rst_vld", ifa.out_valid, 1'b0);
      chk("rst_busy", ifa.busy, 1'b0);
      chk("rst_vec", ifa.out_vec, 64'h0);
      chk("rst_macw1", aw1, 16'h0100);
      chk("rst_macd1", ad1, 16'h0000);
      tick();
      rst_n = 1'b1;
      tick();

      // T1/T2: basic vector, ReLU on and off
      run_vec("t1", 16'h0100, 16'h0200, EXP_A1, EXP_B1);

      // T3: stall in DONE
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_vld", ifa.out_valid, 1'b1);
         chk("t3_vec", ifa.out_vec, EXP_A1);
         chk("t3_rdy", ifa.in_ready, 1'b0);
      end
      ifa.out_ready = 1'b1;
      tick();
      chk("t3_exit_vld", ifa.out_valid, 1'b0);
      chk("t3_exit_rdy", ifa.in_ready, 1'b1);
      chk("t3_exit_busy", ifa.busy, 1'b0);
      ifa.out_ready = 1'b0;

      // T4: in_valid held with new data during RUN is ignored
      ifa.in_d1 = 16'h0100; ifa.in_d2 = 16'h0200; ifa.in_valid = 1'b1;
      tick();
      ifa.in_d1 = 16'h0500;
      repeat (4) tick();
      chk("t4_vld", ifa.out_valid, 1'b1);
      chk("t4_vec", ifa.out_vec, EXP_A1);
      chk("t4_macd1", ad1, 16'h0100);
      ifa.out_ready = 1'b1;
      tick();                                   // DONE -> IDLE, no accept
      chk("t4_idle_rdy", ifa.in_ready, 1'b1);
      chk("t4_idle_d1", ad1, 16'h0100);
      tick();                                   // accept 0x0500
      ifa.in_valid = 1'b0;
      chk("t4_acc_busy", ifa.busy, 1'b1);
      chk("t4_acc_d1", ad1, 16'h0500);
      repeat (4) tick();
      chk("t4b_vld", ifa.out_valid, 1'b1);
      chk("t4b_vec", ifa.out_vec, EXP_A2);
      chk("t4b_vec_lin", ifb.out_vec, EXP_B2);
      tick();
      ifa.out_ready = 1'b0;
      chk("t4b_exit", ifa.in_ready, 1'b1);

      // T5: reset on 2nd RUN cycle
      ifa.in_d1 = 16'h0100; ifa.in_d2 = 16'h0200; ifa.in_valid = 1'b1;
      tick();
      ifa.in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_vld", ifa.out_valid, 1'b0);
      chk("t5_busy", ifa.busy, 1'b0);
      chk("t5_rdy", ifa.in_ready, 1'b1);
      chk("t5_vec", ifa.out_vec, 64'h0);
      tick();
      rst_n = 1'b1;
      run_vec("t5n", 16'h0500, 16'h0200, EXP_A2, EXP_B2);
      ifa.out_ready = 1'b1;
      tick();

      // T6: back-to-back with in_valid and out_ready held high
      begin
         logic [DW-1:0] vd1 [3];
         logic [DW-1:0] vd2 [3];
         logic [63:0]   ve  [3];
         int cyc, nacc, nout, last_acc;
         logic acc;
         vd1 = '{16'h0100, 16'h0500, 16'h0200};
         vd2 = '{16'h0200, 16'h0200, 16'h0100};
         ve  = '{EXP_A1, EXP_A2, EXP_A3};
         cyc = 0; nacc = 0; nout = 0; last_acc = 0;
         ifa.in_d1 = vd1[0]; ifa.in_d2 = vd2[0];
         ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
         while (nout < 3 && cyc < 60) begin
            acc = ifa.in_ready && ifa.in_valid;
            if (ifa.out_valid) begin
               chk("t6_vec", ifa.out_vec, ve[nout]);
               nout++;
            end
            if (acc) begin
               if (nacc > 0) chk("t6_gap", 64'(cyc - last_acc), 64'd6);
               last_acc = cyc;
               nacc++;
            end
            tick();
            cyc++;
            if (acc) begin
               if (nacc < 3) begin
                  ifa.in_d1 = vd1[nacc]; ifa.in_d2 = vd2[nacc];
               end else begin
                  ifa.in_valid = 1'b0;
               end
            end
         end
         chk("t6_nout", 64'(nout), 64'd3);
         chk("t6_nacc", 64'(nacc), 64'd3);
      end
      ifa.out_ready = 1'b0;
      tick();

      // N_OUT=1: a single RUN cycle, ReLU on a negative result
      ifc.in_d1 = 16'h0100; ifc.in_d2 = 16'h0200; ifc.in_valid = 1'b1;
      tick();
      ifc.in_valid = 1'b0;
      chk("n1_busy", ifc.busy, 1'b1);
      chk("n1_vld_early", ifc.out_valid, 1'b0);
      tick();
      chk("n1_vld", ifc.out_valid, 1'b1);
      chk("n1_vec", ifc.out_vec, 16'h0300);
      ifc.out_ready = 1'b1;
      tick();
      chk("n1_exit", ifc.in_ready, 1'b1);
      ifc.in_d1 = 16'hFD00; ifc.in_d2 = 16'h0100; ifc.in_valid = 1'b1;
      tick();
      ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
      tick();
      chk("n1_neg_vld", ifc.out_valid, 1'b1);
      chk("n1_neg_vec", ifc.out_vec, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
